qsram_refresh_bank: RTL



---
 rtl/qsram_pkg.sv | 25 ++
 rtl/qsram_refresh_sched.sv | 105 ++++++++++
 rtl/qsram_refresh_bank.sv | 91 +++++++++
 3 files changed

// File: rtl/qsram_pkg.sv
// Shared types and parameter checks for the QSRAM refresh bank.
// Refresh FSM encoding plus the timing constraints the bank relies on.
package qsram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REF_READ  = 2'd1,
    ST_REF_WRITE = 2'd2
  } ref_state_e;

  localparam int unsigned MIN_DEPTH            = 2;
  localparam int unsigned MIN_REFRESH_INTERVAL = 4;
  localparam int unsigned REFRESH_OP_CYCLES    = 2;

  function automatic bit params_ok(
    input int unsigned depth,
    input int unsigned interval,
    input int unsigned retention
  );
    return (depth >= MIN_DEPTH) &&
           (interval >= MIN_REFRESH_INTERVAL) &&
           (retention > depth * (interval + REFRESH_OP_CYCLES));
  endfunction

endpackage

// File: rtl/qsram_refresh_sched.sv
// Refresh scheduler: interval timer, pending flag, refresh FSM,
// row pointer and retention-sweep watchdog.
module qsram_refresh_sched
  import qsram_pkg::*;
#(
  parameter int DEPTH            = 16,
  parameter int ADDR_W           = $clog2(DEPTH),
  parameter int REFRESH_INTERVAL = 8,
  parameter int RETENTION_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic              idle_o,
  output logic              busy_o,
  output logic              rd_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] row_o,
  output logic              fault_o
);

  localparam int CNT_W = $clog2(REFRESH_INTERVAL);
  localparam int SWP_W = $clog2(RETENTION_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [SWP_W-1:0]  SWP_MAX  = SWP_W'(RETENTION_CYCLES);

  ref_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [SWP_W-1:0]  swp_q, swp_d;
  logic              fault_q, fault_d;
  logic              hit, done, wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      row_q   <= '0;
      swp_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      row_q   <= row_d;
      swp_q   <= swp_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) state_d = ST_REF_READ;
      end
      ST_REF_READ: begin
        busy_o  = 1'b1;
        rd_o    = !rst_i;
        state_d = ST_REF_WRITE;
      end
      ST_REF_WRITE: begin
        busy_o  = 1'b1;
        // a reset landing here aborts the write-back
        wr_o    = !rst_i;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hit  = en_i && (cnt_q == CNT_LAST);
    done = (state_q == ST_REF_WRITE);
    wrap = done && (row_q == ROW_LAST);

    cnt_d = cnt_q;
    if (en_i) cnt_d = hit ? '0 : cnt_q + 1'b1;

    pend_d = pend_q;
    if (hit)       pend_d = 1'b1;
    else if (done) pend_d = 1'b0;

    row_d = row_q;
    if (done) row_d = wrap ? '0 : row_q + 1'b1;

    swp_d = swp_q;
    if (wrap)                 swp_d = '0;
    else if (swp_q != SWP_MAX) swp_d = swp_q + 1'b1;

    fault_d = fault_q || (swp_d == SWP_MAX);
  end

  assign idle_o  = (state_q == ST_IDLE) && !pend_q;
  assign row_o   = row_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/qsram_refresh_bank.sv
// DEPTH x WIDTH quasi-static RAM bank with one request port and
// an integrated refresh scheduler that owns the bank when pending.
module qsram_refresh_bank
  import qsram_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int DEPTH            = 16,
  parameter int ADDR_W           = $clog2(DEPTH),
  parameter int REFRESH_INTERVAL = 8,
  parameter int RETENTION_CYCLES = 256
) (
  input  logic              Clock_i,
  input  logic              Reset_i,
  input  logic              ReqValid_i,
  output logic              ReqReady_o,
  input  logic              ReqWrite_i,
  input  logic [ADDR_W-1:0] ReqAddr_i,
  input  logic [WIDTH-1:0]  ReqData_i,
  output logic              RspValid_o,
  output logic [WIDTH-1:0]  RspData_o,
  input  logic              RefreshEnable_i,
  output logic              RefreshBusy_o,
  output logic [ADDR_W-1:0] RefreshRow_o,
  output logic              RetentionFault_o
);

  if (!params_ok(DEPTH, REFRESH_INTERVAL, RETENTION_CYCLES)) begin : g_bad
    $error("qsram_refresh_bank: illegal parameter combination");
  end

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  buf_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              sch_idle, ref_rd, ref_wr;
  logic [ADDR_W-1:0] ref_row;
  logic              accept, wr_acc, rd_acc, in_range;

  qsram_refresh_sched #(
    .DEPTH            (DEPTH),
    .ADDR_W           (ADDR_W),
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .RETENTION_CYCLES (RETENTION_CYCLES)
  ) u_sched (
    .clk_i   (Clock_i),
    .rst_i   (Reset_i),
    .en_i    (RefreshEnable_i),
    .idle_o  (sch_idle),
    .busy_o  (RefreshBusy_o),
    .rd_o    (ref_rd),
    .wr_o    (ref_wr),
    .row_o   (ref_row),
    .fault_o (RetentionFault_o)
  );

  assign ReqReady_o = sch_idle && !Reset_i;
  assign accept     = ReqValid_i && ReqReady_o;
  assign wr_acc     = accept && ReqWrite_i;
  assign rd_acc     = accept && !ReqWrite_i;
  assign in_range   = {1'b0, ReqAddr_i} < DEPTH_X;

  // Storage is deliberately left unreset
  always_ff @(posedge Clock_i) begin
    if (ref_rd) buf_q <= mem[ref_row];
    if (ref_wr) mem[ref_row] <= buf_q;
    else if (wr_acc && in_range) mem[ReqAddr_i] <= ReqData_i;
  end

  always_comb begin
    rsp_valid_d = rd_acc;
    rsp_data_d  = rsp_data_q;
    if (rd_acc) rsp_data_d = in_range ? mem[ReqAddr_i] : '0;
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign RspValid_o   = rsp_valid_q;
  assign RspData_o    = rsp_data_q;
  assign RefreshRow_o = ref_row;

endmodule
